// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Optional hit/miss/write-back counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int ADDR_W           = 32,
  parameter int BLOCK_BITS       = 128,
  parameter int NUM_SETS         = 16,
  parameter int MEM_BLOCK_ADDR_W = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cpu_ren,
  input  logic                        cpu_wen,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [31:0]                 cpu_wdata,
  input  logic [3:0]                  cpu_byte_en,
  output logic [31:0]                 cpu_rdata,
  output logic                        cpu_stall,
  output logic                        mem_ren,
  output logic                        mem_wen,
  output logic [MEM_BLOCK_ADDR_W-1:0] mem_block_addr,
  output logic [BLOCK_BITS-1:0]       mem_din,
  input  logic [BLOCK_BITS-1:0]       mem_dout,
  input  logic                        mem_ready,
  input  logic                        mem_done,
  output logic [31:0]                 stat_hits,
  output logic [31:0]                 stat_misses,
  output logic [31:0]                 stat_writebacks
);
  localparam int OFF_W   = $clog2(BLOCK_BITS / 8);
  localparam int IDX_W   = $clog2(NUM_SETS);
  localparam int TAG_W   = ADDR_W - OFF_W - IDX_W;
  localparam int WORD_W  = OFF_W - 2;
  localparam int BADDR_W = ADDR_W - OFF_W;

  typedef enum logic [2:0] {IDLE, WB, WB_GAP, FILL, FILL_GAP} state_t;
  state_t state, next_state;

  logic [NUM_SETS-1:0]   valid, dirty;
  logic [TAG_W-1:0]      tag_arr  [NUM_SETS];
  logic [BLOCK_BITS-1:0] data_arr [NUM_SETS];

  logic [IDX_W-1:0]            idx;
  logic [TAG_W-1:0]            tag;
  logic [WORD_W-1:0]           word;
  logic [BADDR_W-1:0]          victim_full;
  logic [MEM_BLOCK_ADDR_W-1:0] miss_baddr, victim_baddr;
  logic                        req_rd, req_wr, req, hit, acc_hit;
  logic                        fill_done, wb_done, miss_start;
  logic                        unused;

  assign idx          = cpu_addr[OFF_W +: IDX_W];
  assign tag          = cpu_addr[ADDR_W-1 -: TAG_W];
  assign word         = cpu_addr[OFF_W-1:2];
  assign unused       = ^cpu_addr[1:0];
  assign victim_full  = {tag_arr[idx], idx};
  assign miss_baddr   = MEM_BLOCK_ADDR_W'(cpu_addr[ADDR_W-1:OFF_W]);
  assign victim_baddr = MEM_BLOCK_ADDR_W'(victim_full);

  // Simultaneous load and store is not a request at all.
  assign req_rd     = cpu_ren && !cpu_wen;
  assign req_wr     = cpu_wen && !cpu_ren;
  assign req        = req_rd || req_wr;
  assign hit        = valid[idx] && (tag_arr[idx] == tag);
  assign acc_hit    = (state == IDLE) && req && hit;
  assign fill_done  = (state == FILL) && mem_ready;
  assign wb_done    = (state == WB) && mem_done;
  assign miss_start = (state == IDLE) && (next_state != IDLE);

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (req && !hit) next_state = (valid[idx] && dirty[idx]) ? WB : FILL;
      WB:       if (mem_done)    next_state = WB_GAP;
      WB_GAP:                    next_state = FILL;
      FILL:     if (mem_ready)   next_state = FILL_GAP;
      FILL_GAP:                  next_state = IDLE;
      default:                   next_state = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    cpu_stall = 1'b1;
    cpu_rdata = '0;
    if (state == IDLE) begin
      cpu_stall = req && !hit;
      if (req_rd && hit) cpu_rdata = data_arr[idx][32*int'(word) +: 32];
    end
  end

  // Memory request lines are registered copies of the next state, so they drop on the accepting edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_ren        <= 1'b0;
      mem_wen        <= 1'b0;
      mem_block_addr <= '0;
      mem_din        <= '0;
    end else begin
      mem_ren <= (next_state == FILL);
      mem_wen <= (next_state == WB);
      if (miss_start) begin
        mem_block_addr <= (next_state == WB) ? victim_baddr : miss_baddr;
        mem_din        <= data_arr[idx];
      end else if (state == WB_GAP) begin
        mem_block_addr <= miss_baddr;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (acc_hit && req_wr) dirty[idx] <= 1'b1;
      if (wb_done)           dirty[idx] <= 1'b0;
      if (fill_done) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
    end
  end

  // NOTE: tag and data arrays are not reset; valid bits alone decide whether their contents mean anything.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (fill_done) begin
        data_arr[idx] <= mem_dout;
        tag_arr[idx]  <= tag;
      end else if (acc_hit && req_wr) begin
        for (int b = 0; b < 4; b++)
          if (cpu_byte_en[b]) data_arr[idx][32*int'(word) + 8*b +: 8] <= cpu_wdata[8*b +: 8];
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset && state == IDLE && cpu_ren && cpu_wen)
      $display("dcache_ctrl: error: cpu_ren and cpu_wen both high at %h, request ignored", cpu_addr);
  end
`endif

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_hits       <= '0;
      stat_misses     <= '0;
      stat_writebacks <= '0;
    end else begin
      if (acc_hit && stat_hits != '1)           stat_hits       <= stat_hits + 32'd1;
      if (miss_start && stat_misses != '1)      stat_misses     <= stat_misses + 32'd1;
      if (wb_done && stat_writebacks != '1)     stat_writebacks <= stat_writebacks + 32'd1;
    end
  end
`else
  assign stat_hits       = '0;
  assign stat_misses     = '0;
  assign stat_writebacks = '0;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a flat-memory reference model predicts load data and
// memory traffic; a negedge monitor pops and compares whenever the DUT presents a response.
module tb_dcache_ctrl;
  localparam int MBA_W = 10;

  logic         clock = 1'b0;
  logic         reset;
  logic         cpu_ren, cpu_wen;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]   cpu_byte_en;
  logic         cpu_stall, mem_ren, mem_wen, mem_ready, mem_done;
  logic [MBA_W-1:0] mem_block_addr;
  logic [127:0] mem_din, mem_dout;
  logic [31:0]  stat_hits, stat_misses, stat_writebacks;

  dcache_ctrl #(.ADDR_W(32), .BLOCK_BITS(128), .NUM_SETS(16), .MEM_BLOCK_ADDR_W(MBA_W)) dut (
    .clock(clock), .reset(reset),
    .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_byte_en(cpu_byte_en), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_block_addr(mem_block_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_ready(mem_ready), .mem_done(mem_done),
    .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_writebacks(stat_writebacks)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit               is_wr;
    logic [MBA_W-1:0] addr;
    logic [127:0]     data;
  } mem_exp_t;

  mem_exp_t     mem_q[$];
  logic [31:0]  load_q[$];
  int           checks = 0;
  int           failures = 0;
  logic [127:0] dram   [1024];
  logic [127:0] shadow [1024];
  bit           m_valid [16];
  bit           m_dirty [16];
  logic [23:0]  m_tag   [16];
  int           read_lat = 4;
  int           write_lat = 2;
  int           n_hits = 0, n_misses = 0, n_wbs = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Read side of the block memory: ready after read_lat cycles, abandoned if ren drops.
  initial begin : rd_resp
    bit alive;
    mem_ready = 1'b0;
    mem_dout  = '0;
    forever begin
      @(posedge clock); #1;
      if (mem_ren) begin
        alive = 1'b1;
        for (int i = 0; i < read_lat; i++) begin
          @(posedge clock); #1;
          if (!mem_ren) begin alive = 1'b0; break; end
        end
        if (alive) begin
          mem_dout  = dram[mem_block_addr];
          mem_ready = 1'b1;
          @(posedge clock); #1;
          mem_ready = 1'b0;
          mem_dout  = '0;
        end
      end
    end
  end

  initial begin : wr_resp
    bit alive;
    mem_done = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (mem_wen) begin
        alive = 1'b1;
        for (int i = 0; i < write_lat; i++) begin
          @(posedge clock); #1;
          if (!mem_wen) begin alive = 1'b0; break; end
        end
        if (alive) begin
          dram[mem_block_addr] = mem_din;
          mem_done = 1'b1;
          @(posedge clock); #1;
          mem_done = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    logic     prev_ren, prev_wen;
    mem_exp_t e;
    logic [31:0] exp_word;
    prev_ren = 1'b0;
    prev_wen = 1'b0;
    forever begin
      @(negedge clock);
      if (mem_ren && !prev_ren) begin
        check("ren_after_gap", {mem_wen, prev_wen}, 2'b00);
        if (mem_q.size() == 0) check("unexpected_mem_read", mem_block_addr, '1);
        else begin
          e = mem_q.pop_front();
          check("mem_read_kind", e.is_wr, 1'b0);
          check("mem_read_addr", mem_block_addr, e.addr);
        end
      end
      if (mem_wen && !prev_wen) begin
        check("wen_alone", mem_ren, 1'b0);
        if (mem_q.size() == 0) check("unexpected_mem_write", mem_block_addr, '1);
        else begin
          e = mem_q.pop_front();
          check("mem_write_kind", e.is_wr, 1'b1);
          check("mem_write_addr", mem_block_addr, e.addr);
          check("mem_write_data", mem_din, e.data);
        end
      end
      if (cpu_ren && !cpu_wen && !cpu_stall) begin
        if (load_q.size() == 0) check("unexpected_load", cpu_rdata, '1);
        else begin
          exp_word = load_q.pop_front();
          check("load_data", cpu_rdata, exp_word);
        end
      end
      prev_ren = mem_ren;
      prev_wen = mem_wen;
    end
  end

  // Predicts hit/miss from direct-mapped placement and the data from a flat memory image.
  task automatic access(input bit st, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    logic [3:0]       idx = addr[7:4];
    logic [23:0]      tg  = addr[31:8];
    logic [MBA_W-1:0] blk = addr[13:4];
    logic [MBA_W-1:0] vb;
    int               w   = int'(addr[3:2]);
    bit               stuck = 1'b1;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      n_misses++;
      if (m_valid[idx] && m_dirty[idx]) begin
        vb = {m_tag[idx][5:0], idx};
        mem_q.push_back('{is_wr: 1'b1, addr: vb, data: shadow[vb]});
        n_wbs++;
      end
      mem_q.push_back('{is_wr: 1'b0, addr: blk, data: '0});
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    if (st) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) shadow[blk][32*w + 8*b +: 8] = wd[8*b +: 8];
      m_dirty[idx] = 1'b1;
    end else begin
      load_q.push_back(shadow[blk][32*w +: 32]);
    end
    n_hits++;
    cpu_addr = addr; cpu_ren = !st; cpu_wen = st; cpu_wdata = wd; cpu_byte_en = be;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (!cpu_stall) begin stuck = 1'b0; break; end
    end
    if (stuck) check("stall_timeout", 1'b1, 1'b0);
    @(posedge clock); #1;
    cpu_ren = 1'b0; cpu_wen = 1'b0;
  endtask

  task automatic check_stats(input string tag_name);
`ifdef DCACHE_STATS_EN
    check({tag_name, "_stat_hits"}, stat_hits, n_hits);
    check({tag_name, "_stat_misses"}, stat_misses, n_misses);
    check({tag_name, "_stat_writebacks"}, stat_writebacks, n_wbs);
`else
    check({tag_name, "_stats_tied"}, {stat_hits, stat_misses, stat_writebacks}, '0);
`endif
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : stimulus
    bit stuck;
    for (int i = 0; i < 1024; i++) dram[i] = {$urandom, $urandom, $urandom, $urandom};
    dram[4] = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
    for (int i = 0; i < 1024; i++) shadow[i] = dram[i];
    reset = 1'b1; cpu_ren = 1'b0; cpu_wen = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_byte_en = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_mem_req", {mem_ren, mem_wen}, 2'b00);
    check("reset_block_addr", mem_block_addr, '0);
    check("reset_mem_din", mem_din, '0);
    check("idle_stall", cpu_stall, 1'b0);
    check("idle_rdata", cpu_rdata, '0);
    @(posedge clock); #1;

    // Cold miss, hits in the filled line, then a dirty eviction by a conflicting tag.
    access(1'b0, 32'h40, '0, '0);
    access(1'b0, 32'h44, '0, '0);
    access(1'b0, 32'h48, '0, '0);
    access(1'b1, 32'h40, 32'h1234_5678, 4'b0011);
    access(1'b0, 32'h440, '0, '0);
    check_stats("directed");

    // Reset while a refill is outstanding.
    mem_q.push_back('{is_wr: 1'b0, addr: 10'h4, data: '0});
    cpu_addr = 32'h40; cpu_ren = 1'b1;
    stuck = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (mem_ren) begin stuck = 1'b0; break; end
    end
    if (stuck) check("fill_start_timeout", 1'b1, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1; cpu_ren = 1'b0;
    @(posedge clock); #1;
    check("reset_drops_ren", mem_ren, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
    n_hits = 0; n_misses = 0; n_wbs = 0;
    access(1'b0, 32'h40, '0, '0);

    // Load and store together: ignored, cache untouched.
    cpu_addr = 32'h40; cpu_ren = 1'b1; cpu_wen = 1'b1; cpu_wdata = '1; cpu_byte_en = '1;
    repeat (2) begin
      @(negedge clock);
      check("both_req_stall", cpu_stall, 1'b0);
    end
    @(posedge clock); #1;
    cpu_ren = 1'b0; cpu_wen = 1'b0;
    access(1'b0, 32'h40, '0, '0);

    // Randomized loads/stores over a few conflicting tags with varying memory latency.
    for (int n = 0; n < 120; n++) begin
      read_lat  = $urandom_range(1, 5);
      write_lat = $urandom_range(1, 4);
      access(1'($urandom_range(0, 1)),
             32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4) | ($urandom_range(0, 3) << 2)),
             $urandom, 4'($urandom_range(0, 15)));
    end

    @(negedge clock);
    check("final_idle_stall", cpu_stall, 1'b0);
    check("final_idle_rdata", cpu_rdata, '0);
    check("mem_queue_drained", mem_q.size(), 0);
    check("load_queue_drained", load_q.size(), 0);
    check_stats("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
